systolic_result_drain: RTL and testbench

//  Output-side companion of the 4x4 output-stationary systolic array.
//  - On the array's done rising edge, snapshots all NxN PE accumulators into a local buffer.
//  - Streams the snapshot out one word per beat over a valid/ready interface, row-major.
//  - Frees the array to start the next matrix product as soon as the snapshot is taken.

---
 rtl/systolic_result_drain.sv | 124 ++++++++++++
 tb/tb_systolic_result_drain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// ============================================================================
// Module  : systolic_result_drain
// Brief   : Snapshots the NxN PE accumulators on done rising edge and streams
//           them out one word per valid/ready beat. Optional build macro
//           DRAIN_TRANSPOSE_EN switches to column-major (transposed) order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_result_drain #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [N*N*DW-1:0] acc_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [IW-1:0]     out_row,
  output logic [IW-1:0]     out_col,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int WORDS = N * N;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);
  localparam logic [CW-1:0] N_C      = CW'(N);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic [DW-1:0]   mem [WORDS];

  logic            rise;
  logic            beat;
  logic            at_last;
  logic            take;
  logic [CW-1:0]   nxt_cnt;
  logic [CW-1:0]   major;
  logic [CW-1:0]   minor;
  logic [CW-1:0]   nxt_addr;
  logic [IW-1:0]   nxt_row;
  logic [IW-1:0]   nxt_col;

  assign rise    = done & ~done_q;
  assign beat    = out_valid & out_ready;
  assign at_last = (cnt == LAST_CNT);
  // A rise coinciding with the final beat starts the next frame back-to-back.
  assign take    = rise & ((state == IDLE) | (beat & at_last));

  always_comb begin
    nxt_cnt = cnt + CW'(1);
    major   = nxt_cnt / N_C;
    minor   = nxt_cnt % N_C;
`ifdef DRAIN_TRANSPOSE_EN
    nxt_row  = IW'(minor);
    nxt_col  = IW'(major);
    nxt_addr = minor * N_C + major;
`else
    nxt_row  = IW'(major);
    nxt_col  = IW'(minor);
    nxt_addr = nxt_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    // Sampled even in reset so a done held across reset is not seen as a rise.
    done_q <= done;
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (take) begin
        for (int i = 0; i < WORDS; i++) begin
          mem[i] <= acc_flat[i*DW +: DW];
        end
        state     <= STREAM;
        cnt       <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_data  <= acc_flat[DW-1:0];
        out_row   <= '0;
        out_col   <= '0;
        out_last  <= (WORDS == 1);
      end else if ((state == STREAM) && beat) begin
        if (at_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end else begin
          cnt      <= nxt_cnt;
          out_data <= mem[nxt_addr];
          out_row  <= nxt_row;
          out_col  <= nxt_col;
          out_last <= (nxt_cnt == LAST_CNT);
        end
      end
      if ((state == STREAM) && rise && !take) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
// ============================================================================
// Module  : tb_systolic_result_drain
// Brief   : Self-checking bench for systolic_result_drain (table + scoreboard).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              done;
  logic [N*N*DW-1:0] acc_flat;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_row;
  logic [IW-1:0]     out_col;
  logic              out_last;
  logic              busy;
  logic              overrun;

  systolic_result_drain #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .acc_flat  (acc_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
  } beat_t;

  typedef struct {
    logic          rst;
    logic          done;
    logic          valid;
    logic          busy;
    logic          ovr;
    logic [DW-1:0] data;
  } vec_t;

  beat_t         sb[$];
  vec_t          tbl[5];
  int            nvec  = 0;
  int            nfail = 0;
  int            guard;
  logic          stalled;
  logic [DW-1:0] pd;
  logic [IW-1:0] pr;
  logic [IW-1:0] pc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_acc(input logic [31:0] base);
    for (int k = 0; k < N*N; k++) acc_flat[k*DW +: DW] = base + 32'(k);
  endtask

  task automatic push_frame(input logic [31:0] base);
    beat_t e;
    for (int k = 0; k < N*N; k++) begin
`ifdef DRAIN_TRANSPOSE_EN
      e.row = IW'(k % N);
      e.col = IW'(k / N);
`else
      e.row = IW'(k / N);
      e.col = IW'(k % N);
`endif
      e.data = base + 32'(int'(e.row) * N + int'(e.col));
      e.last = (k == N*N-1);
      sb.push_back(e);
    end
  endtask

  // One clock: score the beat (if any) that this edge accepts, then advance.
  task automatic cyc();
    beat_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL beat_unexpected: got data %0h expected no beat", out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_row",  32'(out_row), 32'(e.row));
        chk("beat_col",  32'(out_col), 32'(e.col));
        chk("beat_last", 32'(out_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, done -> valid, busy, overrun, data after the edge
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    out_ready = 1'b1;
    set_acc(32'd100);
    #1;
    for (int i = 0; i < 5; i++) begin
      rst  = tbl[i].rst;
      done = tbl[i].done;
      cyc();
      chk("tbl_valid",   32'(out_valid), 32'(tbl[i].valid));
      chk("tbl_busy",    32'(busy),      32'(tbl[i].busy));
      chk("tbl_overrun", 32'(overrun),   32'(tbl[i].ovr));
      chk("tbl_data",    out_data,       tbl[i].data);
    end

    // Basic frame with out_ready held high
    done = 1'b1;
    push_frame(32'd100);
    cyc();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_busy",  32'(busy),      32'd1);
    done = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      chk("stream_valid", 32'(out_valid), 32'd1);
      cyc();
    end
    chk("end_valid",   32'(out_valid), 32'd0);
    chk("end_busy",    32'(busy),      32'd0);
    chk("end_last",    32'(out_last),  32'd0);
    chk("end_overrun", 32'(overrun),   32'd0);

    // Backpressure plus snapshot isolation
    done = 1'b1;
    push_frame(32'd100);
    cyc();
    done     = 1'b0;
    acc_flat = {N*N{32'hDEAD_BEEF}};
    guard    = 0;
    stalled  = 1'b0;
    while (sb.size() > 0 && guard < 200) begin
      out_ready = (guard % 3 == 0);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data",  out_data, pd);
        chk("stall_row",   32'(out_row), 32'(pr));
        chk("stall_col",   32'(out_col), 32'(pc));
      end
      stalled = out_valid && !out_ready;
      pd = out_data;
      pr = out_row;
      pc = out_col;
      cyc();
      guard++;
    end
    if (guard >= 200) begin
      nvec++;
      nfail++;
      $display("FAIL bp_timeout: got %0d beats left expected 0", sb.size());
    end
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    chk("bp_end_busy",  32'(busy),      32'd0);

    // Overrun mid-frame, then back-to-back on the last beat
    out_ready = 1'b1;
    set_acc(32'd200);
    done = 1'b1;
    push_frame(32'd200);
    cyc();
    chk("pre_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < N*N; i++) begin
      done = (i == 5);
      if (i == N*N-1) begin
        done = 1'b1;
        set_acc(32'd300);
        push_frame(32'd300);
      end
      cyc();
      if (i == 5) chk("overrun_set", 32'(overrun), 32'd1);
    end
    chk("b2b_valid",   32'(out_valid), 32'd1);
    chk("b2b_busy",    32'(busy),      32'd1);
    chk("b2b_data",    out_data,       32'd300);
    chk("b2b_overrun", 32'(overrun),   32'd1);
    done = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Mid-frame reset aborts the frame and clears overrun
    out_ready = 1'b0;
    rst = 1'b0;
    cyc();
    sb.delete();
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_data",    out_data,       32'd0);
    chk("rst_row",     32'(out_row),   32'd0);
    chk("rst_col",     32'(out_col),   32'd0);
    chk("rst_last",    32'(out_last),  32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
